// File: rtl/rx_byte_buffer_if.sv
// rx_byte_buffer_if: handshake bundle for rx_byte_buffer.
//   Decoder side : dec_data, dec_avail, dec_error (towards buffer), dec_read (back)
//   Player side  : out_data, out_valid (towards player), out_ready (back)
//   slave  modport is taken by the buffer, master modport by whoever drives it.
interface rx_byte_buffer_if #(
  parameter int N_PKT = 8
);
  logic [N_PKT-1:0] dec_data;
  logic             dec_avail;
  logic             dec_error;
  logic             dec_read;
  logic [N_PKT-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  dec_data, dec_avail, dec_error, out_ready,
    output dec_read, out_data, out_valid
  );

  modport master (
    output dec_data, dec_avail, dec_error, out_ready,
    input  dec_read, out_data, out_valid
  );
endinterface

// File: rtl/rx_byte_buffer.sv
// rx_byte_buffer: drains decoded bytes from the Decoder's avail/read handshake
// into a small first-word-fall-through FIFO and offers them to the player over
// valid/ready. Corrupt bytes and bytes arriving while full are acknowledged and
// dropped (and counted) so the optical link never stalls on a slow player.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   bus          : rx_byte_buffer_if.slave (decoder handshake + output stream)
//   flush        : synchronous FIFO clear (pointers and occupancy only)
//   clr_stats    : synchronous clear of error_ct / overflow_ct
//   count, full  : current occupancy and count == DEPTH
//   error_ct     : bytes dropped because dec_error was set (saturating)
//   overflow_ct  : bytes dropped because the FIFO was full (saturating)
module rx_byte_buffer #(
  parameter int N_PKT = 8,
  parameter int DEPTH = 4,
  parameter int CT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rx_byte_buffer_if.slave          bus,
  input  logic                     flush,
  input  logic                     clr_stats,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [CT_W-1:0]          error_ct,
  output logic [CT_W-1:0]          overflow_ct
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CT_W-1:0] CT_ONE   = {{(CT_W-1){1'b0}}, 1'b1};
  localparam logic [CT_W-1:0] CT_MAX   = {CT_W{1'b1}};

  typedef enum logic [0:0] {
    S_WAIT = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t           state_r;
  logic             dec_read_r;
  logic [N_PKT-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             valid_r;
  logic             full_r;
  logic [CT_W-1:0]  error_ct_r;
  logic [CT_W-1:0]  overflow_ct_r;

  logic take_s;
  logic push_s;
  logic pop_s;
  logic err_inc_s;
  logic ovf_inc_s;

  // A byte is taken only on the S_WAIT edge; its fate is decided from that edge's
  // inputs with flush > error > full priority. Full is the pre-edge occupancy,
  // so a same-cycle pop never makes room for the push.
  assign take_s    = (state_r == S_WAIT) && bus.dec_avail;
  assign push_s    = take_s && !flush && !bus.dec_error && !full_r;
  assign err_inc_s = take_s && !flush && bus.dec_error;
  assign ovf_inc_s = take_s && !flush && !bus.dec_error && full_r;
  assign pop_s     = valid_r && bus.out_ready && !flush;

  // Next occupancy: flush wins, otherwise count += push - pop
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = {CW{1'b0}};
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Intake FSM: one-cycle dec_read per offered byte, then wait for avail to drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_WAIT;
      dec_read_r <= 1'b0;
    end else begin
      case (state_r)
        S_WAIT: begin
          if (bus.dec_avail) begin
            dec_read_r <= 1'b1;
            state_r    <= S_ACK;
          end else begin
            dec_read_r <= 1'b0;
            state_r    <= S_WAIT;
          end
        end
        S_ACK: begin
          dec_read_r <= 1'b0;
          if (!bus.dec_avail) begin
            state_r <= S_WAIT;
          end else begin
            state_r <= S_ACK;
          end
        end
        default: begin
          dec_read_r <= 1'b0;
          state_r    <= S_WAIT;
        end
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.dec_data;
    end
  end

  // FIFO pointers and occupancy flags, registered from next occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr_r <= {AW{1'b0}};
        wr_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {CW{1'b0}});
      full_r  <= (count_nxt_s == CNT_FULL);
    end
  end

  // Saturating drop statistics; clr_stats beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_ct_r    <= {CT_W{1'b0}};
      overflow_ct_r <= {CT_W{1'b0}};
    end else if (clr_stats) begin
      error_ct_r    <= {CT_W{1'b0}};
      overflow_ct_r <= {CT_W{1'b0}};
    end else begin
      if (err_inc_s && (error_ct_r != CT_MAX)) begin
        error_ct_r <= error_ct_r + CT_ONE;
      end
      if (ovf_inc_s && (overflow_ct_r != CT_MAX)) begin
        overflow_ct_r <= overflow_ct_r + CT_ONE;
      end
    end
  end

  assign bus.dec_read  = dec_read_r;
  assign bus.out_data  = mem_r[rd_ptr_r];
  assign bus.out_valid = valid_r;
  assign count         = count_r;
  assign full          = full_r;
  assign error_ct      = error_ct_r;
  assign overflow_ct   = overflow_ct_r;

endmodule

// File: tb/tb_rx_byte_buffer.sv
// tb_rx_byte_buffer: directed bench for rx_byte_buffer (N_PKT=8, DEPTH=4, CT_W=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// half a cycle after the rising edge they reflect.
module tb_rx_byte_buffer;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       clr_stats;
  logic [2:0] count;
  logic       full;
  logic [7:0] error_ct;
  logic [7:0] overflow_ct;

  int vectors;
  int miscompares;

  rx_byte_buffer_if #(.N_PKT(8)) bus ();

  rx_byte_buffer #(.N_PKT(8), .DEPTH(4), .CT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush       (flush),
    .clr_stats   (clr_stats),
    .count       (count),
    .full        (full),
    .error_ct    (error_ct),
    .overflow_ct (overflow_ct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running properties: no back-to-back dec_read, occupancy never above DEPTH
  logic prev_read;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_read = 1'b0;
    end else begin
      vectors++;
      if (bus.dec_read === 1'b1 && prev_read === 1'b1) begin
        miscompares++;
        $display("FAIL dec_read_twice: got 1 in two consecutive cycles, want a single-cycle pulse");
      end
      vectors++;
      if (count > 3'd4) begin
        miscompares++;
        $display("FAIL count_bound: got %0d want <= 4", count);
      end
      prev_read = bus.dec_read;
    end
  end

  // Full Decoder handshake: offer, expect dec_read next cycle, hold avail one
  // more cycle (must not be read again), then drop avail.
  task automatic send_byte(input logic [7:0] d, input logic e,
                           output logic [7:0] rd_data, output logic rd_valid,
                           output logic [2:0] rd_count);
    @(negedge clk);
    bus.dec_avail = 1'b1;
    bus.dec_data  = d;
    bus.dec_error = e;
    @(negedge clk);
    vectors++;
    if (bus.dec_read !== 1'b1) begin
      miscompares++;
      $display("FAIL dec_read_pulse: got %b want 1 (byte %h)", bus.dec_read, d);
    end
    rd_data  = bus.out_data;
    rd_valid = bus.out_valid;
    rd_count = count;
    bus.dec_data  = 8'hEE;
    bus.dec_error = ~e;
    @(negedge clk);
    vectors++;
    if (bus.dec_read !== 1'b0) begin
      miscompares++;
      $display("FAIL dec_read_held: got %b want 0 (byte %h)", bus.dec_read, d);
    end
    bus.dec_avail = 1'b0;
    bus.dec_error = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.dec_avail = 1'b0; bus.dec_error = 1'b0; bus.dec_data = 8'h00;
    bus.out_ready = 1'b0; flush = 1'b0; clr_stats = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.dec_read, bus.out_valid, full, count, error_ct, overflow_ct} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_values: got read=%b valid=%b full=%b count=%0d err=%0d ovf=%0d want all 0",
               bus.dec_read, bus.out_valid, full, count, error_ct, overflow_ct);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    logic [7:0] bytes [3];
    logic [7:0] d; logic v; logic [2:0] c;
    bytes[0] = 8'h42; bytes[1] = 8'h8f; bytes[2] = 8'h11;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], 1'b0, d, v, c);
      vectors++;
      if (d !== bytes[i] || v !== 1'b1 || c !== 3'd1) begin
        miscompares++;
        $display("FAIL pass_through: got data=%h valid=%b count=%0d want data=%h valid=1 count=1",
                 d, v, c, bytes[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if (count !== 3'd0 || error_ct !== 8'd0) begin
      miscompares++;
      $display("FAIL pass_through_end: got count=%0d err=%0d want 0 0", count, error_ct);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] d; logic v; logic [2:0] c;
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'(i), 1'b0, d, v, c);
      vectors++;
      if (c !== 3'(i) || d !== 8'h01) begin
        miscompares++;
        $display("FAIL fill: got count=%0d head=%h want count=%0d head=01", c, d, i);
      end
    end
    vectors++;
    if (full !== 1'b1 || count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_flag: got full=%b count=%0d want 1 4", full, count);
    end
    send_byte(8'h05, 1'b0, d, v, c);
    vectors++;
    if (overflow_ct !== 8'd1 || count !== 3'd4) begin
      miscompares++;
      $display("FAIL overflow: got ovf=%0d count=%0d want 1 4", overflow_ct, count);
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i)) begin
        miscompares++;
        $display("FAIL drain_order: got valid=%b data=%h want 1 %h", bus.out_valid, bus.out_data, 8'(i));
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: got valid=%b count=%0d full=%b want 0 0 0", bus.out_valid, count, full);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_error_drop();
    logic [7:0] d; logic v; logic [2:0] c;
    send_byte(8'hAA, 1'b1, d, v, c);
    send_byte(8'hBB, 1'b0, d, v, c);
    vectors++;
    if (error_ct !== 8'd1 || count !== 3'd1 || bus.out_data !== 8'hBB || overflow_ct !== 8'd1) begin
      miscompares++;
      $display("FAIL error_drop: got err=%0d count=%0d data=%h ovf=%0d want 1 1 bb 1",
               error_ct, count, bus.out_data, overflow_ct);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    vectors++;
    if (count !== 3'd0) begin
      miscompares++;
      $display("FAIL error_drop_pop: got count=%0d want 0", count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic v; logic [2:0] c;
    send_byte(8'hC0, 1'b0, d, v, c);
    send_byte(8'hC1, 1'b0, d, v, c);
    @(negedge clk);
    bus.dec_avail = 1'b1; bus.dec_data = 8'hC2; bus.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (count !== 3'd2 || bus.dec_read !== 1'b1 || bus.out_data !== 8'hC1) begin
      miscompares++;
      $display("FAIL push_pop: got count=%0d read=%b head=%h want 2 1 c1", count, bus.dec_read, bus.out_data);
    end
    bus.out_ready = 1'b0; bus.dec_data = 8'hEE;
    @(negedge clk);
    bus.dec_avail = 1'b0;
    bus.out_ready = 1'b1;
    vectors++;
    if (bus.out_data !== 8'hC1) begin
      miscompares++;
      $display("FAIL push_pop_order0: got %h want c1", bus.out_data);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_data !== 8'hC2 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL push_pop_order1: got %h valid=%b want c2 1", bus.out_data, bus.out_valid);
    end
    @(negedge clk);
    // ten bytes straight through, crossing the pointer wrap more than once
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h50 + 8'(i), 1'b0, d, v, c);
      vectors++;
      if (d !== 8'h50 + 8'(i) || c !== 3'd1) begin
        miscompares++;
        $display("FAIL wrap_order: got data=%h count=%0d want %h 1", d, c, 8'h50 + 8'(i));
      end
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic [7:0] d; logic v; logic [2:0] c;
    send_byte(8'hD0, 1'b0, d, v, c);
    send_byte(8'hD1, 1'b0, d, v, c);
    send_byte(8'hD2, 1'b0, d, v, c);
    @(negedge clk);
    bus.dec_avail = 1'b1; bus.dec_data = 8'hD3; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.dec_read !== 1'b1) begin
      miscompares++;
      $display("FAIL flush: got count=%0d valid=%b read=%b want 0 0 1", count, bus.out_valid, bus.dec_read);
    end
    @(negedge clk);
    bus.dec_avail = 1'b0;
    vectors++;
    if (bus.dec_read !== 1'b0 || error_ct !== 8'd1 || overflow_ct !== 8'd1) begin
      miscompares++;
      $display("FAIL flush_side: got read=%b err=%0d ovf=%0d want 0 1 1", bus.dec_read, error_ct, overflow_ct);
    end
    send_byte(8'hE5, 1'b0, d, v, c);
    vectors++;
    if (d !== 8'hE5 || c !== 3'd1) begin
      miscompares++;
      $display("FAIL after_flush: got data=%h count=%0d want e5 1", d, c);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stats();
    logic [7:0] d; logic v; logic [2:0] c;
    @(negedge clk);
    bus.dec_avail = 1'b1; bus.dec_error = 1'b1; clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    vectors++;
    if (error_ct !== 8'd0 || overflow_ct !== 8'd0) begin
      miscompares++;
      $display("FAIL clr_priority: got err=%0d ovf=%0d want 0 0", error_ct, overflow_ct);
    end
    @(negedge clk);
    bus.dec_avail = 1'b0; bus.dec_error = 1'b0;
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 1'b1, d, v, c);
    end
    vectors++;
    if (error_ct !== 8'd255 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL err_saturate: got err=%0d count=%0d want 255 0", error_ct, count);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] d; logic v; logic [2:0] c;
    send_byte(8'hF0, 1'b0, d, v, c);
    send_byte(8'hF1, 1'b0, d, v, c);
    @(negedge clk);
    bus.dec_avail = 1'b1; bus.dec_data = 8'hF2; bus.dec_error = 1'b1;
    @(negedge clk);
    vectors++;
    if (count !== 3'd2 || bus.dec_read !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: got count=%0d read=%b want 2 1", count, bus.dec_read);
    end
    #2;
    rst_n = 1'b0;
    bus.dec_data = 8'hF3; bus.dec_error = 1'b0;
    #1;
    vectors++;
    if ({bus.dec_read, bus.out_valid, full, count, error_ct, overflow_ct} !== 22'd0) begin
      miscompares++;
      $display("FAIL async_reset: got read=%b valid=%b full=%b count=%0d err=%0d ovf=%0d want all 0",
               bus.dec_read, bus.out_valid, full, count, error_ct, overflow_ct);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.dec_read !== 1'b1 || count !== 3'd1 || bus.out_data !== 8'hF3 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset: got read=%b count=%0d data=%h valid=%b want 1 1 f3 1",
               bus.dec_read, count, bus.out_data, bus.out_valid);
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (bus.dec_read !== 1'b0 || count !== 3'd1) begin
        miscompares++;
        $display("FAIL post_reset_hold: got read=%b count=%0d want 0 1", bus.dec_read, count);
      end
    end
    bus.dec_avail = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    prev_read = 1'b0;
    test_reset();
    test_pass_through();
    test_overflow();
    test_error_drop();
    test_back_to_back();
    test_flush();
    test_stats();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
